clm_aes_scheduler: RTL and testbench
====================================

CLM_AES_SCHEDULER -- requirements
Module: clm_aes_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters sharing one CLM AES core (range 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum cycles from launch to core completion.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid / req_ready  input / output  N_REQ  per-requester job handshake.
REQ-006 SHALL have ports req_plaintext / req_key  input  N_REQ x 128  per-requester job data.
REQ-007 SHALL have ports resp_valid / resp_err  output  N_REQ  one-cycle completion / timeout pulses.
REQ-008 SHALL have port resp_ciphertext  output  128  result of the most recently completed job.
REQ-009 SHALL have ports p_det_in / p_det_valid  input  p_det_t / 1  fresh detection polynomial from TRNG.
REQ-010 SHALL have ports core_drdy_i / core_abort  output  1  core start pulse / core reset request.
REQ-011 SHALL have ports core_plaintext / core_key  output  128  data to the core.
REQ-012 SHALL have port core_p_det  output  p_det_t  polynomial to the core.
REQ-013 SHALL have ports core_drdy_o / core_ciphertext  input  1 / 128  core completion and result.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, LAUNCH, WAIT, RESP, ERR.
REQ-016 IDLE: if any req_valid, SHALL grant one requester round-robin (first index after last grant, wrapping); req_ready[grant] high that cycle only; latch plaintext, key, grant index; go LAUNCH.
REQ-017 Grant SHALL occur only in IDLE; req_ready SHALL be 0 for non-granted and in all other states.
REQ-018 p_det: shadow register loaded on any cycle p_det_valid=1; copied to core_p_det only on the IDLE->LAUNCH transition; core_p_det SHALL be stable LAUNCH through RESP/ERR.
REQ-019 If no p_det_valid seen since last job, SHALL reuse the previous value (no stall).
REQ-020 LAUNCH: core_drdy_i=1 for exactly one cycle; go WAIT; core_plaintext/core_key held stable from LAUNCH until exit of WAIT.
REQ-021 WAIT: timeout counter increments from 0 each cycle; core_drdy_o=1 -> capture core_ciphertext into resp_ciphertext, go RESP.
REQ-022 WAIT: counter reaching TIMEOUT without core_drdy_o -> go ERR; core_drdy_o on the same cycle SHALL win (RESP).
REQ-023 RESP: resp_valid[grant]=1 one cycle; go IDLE; resp_ciphertext held until next RESP.
REQ-024 ERR: resp_err[grant]=1 and core_abort=1 for one cycle; resp_ciphertext unchanged; go IDLE.
REQ-025 core_drdy_o outside WAIT SHALL be ignored.
REQ-026 Minimum job-to-job gap: RESP->IDLE->grant, i.e. next core_drdy_i no earlier than 3 cycles after core_drdy_o.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, all outputs 0, resp_ciphertext 0, core_p_det and shadow 0, last-grant pointer N_REQ-1 (so requester 0 has first priority), counter 0.
REQ-028 Reset mid-job SHALL drop the job with no resp_valid/resp_err; core_abort not asserted (top-level reset covers the core).

Structure
REQ-029 sched_state_t enum and TIMEOUT default constant SHALL live in the shared types package; p_det_t reused from it.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, last pointer; outputs one-hot grant, index).

Verification
REQ-031 Single job req 0 (FIPS-197 key 000102..0f, pt 00112233..ff) -> one core_drdy_i, resp_valid[0] with ct 69c4e0d8..c55a.
REQ-032 req_valid 0 and 1 held high continuously -> grants alternate 0,1,0,1 over 4 jobs.
REQ-033 Core model never asserts drdy_o, TIMEOUT=15 -> resp_err pulse and core_abort 16 cycles after LAUNCH, return to IDLE.
REQ-034 p_det_valid pulses with values A then B during WAIT -> current job keeps old value; next job core_p_det=B.
REQ-035 core_drdy_o on cycle counter==TIMEOUT -> resp_valid, no resp_err.
REQ-036 rst_n low during WAIT -> all outputs 0 next cycle asynchronously, no response pulse; next job granted to requester 0.

Source files
------------

// File: rtl/clm_aes_scheduler_pkg.sv
// Shared types for the CLM AES job scheduler.
//   p_det_t        : detection polynomial handed from the TRNG to the core
//   sched_state_t  : scheduler FSM states
//   TIMEOUT_DEFAULT: default launch-to-completion cycle budget
package clm_aes_scheduler_pkg;

  localparam int BLOCK_W         = 128;
  localparam int P_DET_W         = 32;
  localparam int TIMEOUT_DEFAULT = 1023;

  typedef logic [P_DET_W-1:0] p_det_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP,
    ERR
  } sched_state_t;

endpackage

// File: rtl/clm_aes_scheduler_rr_arbiter.sv
// Round-robin arbiter used by the CLM AES scheduler.
//   req       : per-requester request vector
//   last_idx  : index granted last time; search starts at last_idx+1
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : binary index of the granted requester
//   any_req   : at least one request present
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic           found;
  logic [IDX_W:0] cand;  // one extra bit so last_idx+offset never overflows before wrapping

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = {1'b0, last_idx} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                    = 1'b1;
        grant[cand[IDX_W-1:0]]   = 1'b1;
        grant_idx                = cand[IDX_W-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/clm_aes_scheduler.sv
// Shares one CLM AES core between N_REQ requesters.
//   req_valid/req_ready, req_plaintext/req_key : per-requester job handshake + data
//   resp_valid/resp_err                        : one-cycle completion / timeout pulses
//   resp_ciphertext                            : result of the last successful job
//   p_det_in/p_det_valid                       : fresh detection polynomial from the TRNG
//   core_drdy_i/core_abort                     : core start pulse / core reset request
//   core_plaintext/core_key/core_p_det         : operands presented to the core
//   core_drdy_o/core_ciphertext                : core completion and result
//   busy                                       : high whenever a job is in flight
module clm_aes_scheduler
  import clm_aes_scheduler_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0][BLOCK_W-1:0]   req_plaintext,
  input  logic [N_REQ-1:0][BLOCK_W-1:0]   req_key,
  output logic [N_REQ-1:0]                resp_valid,
  output logic [N_REQ-1:0]                resp_err,
  output logic [BLOCK_W-1:0]              resp_ciphertext,
  input  p_det_t                          p_det_in,
  input  logic                            p_det_valid,
  output logic                            core_drdy_i,
  output logic                            core_abort,
  output logic [BLOCK_W-1:0]              core_plaintext,
  output logic [BLOCK_W-1:0]              core_key,
  output p_det_t                          core_p_det,
  input  logic                            core_drdy_o,
  input  logic [BLOCK_W-1:0]              core_ciphertext,
  output logic                            busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sched_state_t        state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;  // also the index of the job in flight
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BLOCK_W-1:0]  pt_q, pt_d;
  logic [BLOCK_W-1:0]  key_q, key_d;
  logic [BLOCK_W-1:0]  resp_ct_q, resp_ct_d;
  p_det_t              p_det_shadow_q, p_det_shadow_d;
  p_det_t              core_p_det_q, core_p_det_d;

  logic [N_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .last_idx  (last_grant_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    pt_d           = pt_q;
    key_d          = key_q;
    resp_ct_d      = resp_ct_q;
    core_p_det_d   = core_p_det_q;
    // The shadow tracks the TRNG continuously; the core only sees it at grant time.
    p_det_shadow_d = p_det_valid ? p_det_in : p_det_shadow_q;

    req_ready   = '0;
    resp_valid  = '0;
    resp_err    = '0;
    core_drdy_i = 1'b0;
    core_abort  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready    = arb_grant;
          last_grant_d = arb_idx;
          pt_d         = req_plaintext[arb_idx];
          key_d        = req_key[arb_idx];
          core_p_det_d = p_det_shadow_q;
          cnt_d        = '0;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        core_drdy_i = 1'b1;
        // First WAIT cycle sees count 1, so a completion exactly TIMEOUT
        // cycles after the launch pulse still lands inside WAIT.
        cnt_d       = CNT_W'(1);
        state_d     = WAIT;
      end
      WAIT: begin
        if (core_drdy_o) begin
          resp_ct_d = core_ciphertext;
          cnt_d     = '0;
          state_d   = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          cnt_d   = '0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        resp_valid[last_grant_q] = 1'b1;
        state_d                  = IDLE;
      end
      ERR: begin
        resp_err[last_grant_q] = 1'b1;
        core_abort             = 1'b1;
        state_d                = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_grant_q   <= IDX_W'(N_REQ - 1);
      cnt_q          <= '0;
      pt_q           <= '0;
      key_q          <= '0;
      resp_ct_q      <= '0;
      p_det_shadow_q <= '0;
      core_p_det_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      pt_q           <= pt_d;
      key_q          <= key_d;
      resp_ct_q      <= resp_ct_d;
      p_det_shadow_q <= p_det_shadow_d;
      core_p_det_q   <= core_p_det_d;
    end
  end

  assign core_plaintext  = pt_q;
  assign core_key        = key_q;
  assign core_p_det      = core_p_det_q;
  assign resp_ciphertext = resp_ct_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_clm_aes_scheduler.sv
module tb_clm_aes_scheduler;
  import clm_aes_scheduler_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 15;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid, req_ready, resp_valid, resp_err;
  logic [N-1:0][127:0]  req_plaintext, req_key;
  logic [127:0]         resp_ciphertext, core_plaintext, core_key, core_ciphertext;
  p_det_t               p_det_in, core_p_det;
  logic                 p_det_valid, core_drdy_i, core_abort, core_drdy_o, busy;

  clm_aes_scheduler #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext(req_plaintext), .req_key(req_key),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_ciphertext(resp_ciphertext),
    .p_det_in(p_det_in), .p_det_valid(p_det_valid),
    .core_drdy_i(core_drdy_i), .core_abort(core_abort),
    .core_plaintext(core_plaintext), .core_key(core_key), .core_p_det(core_p_det),
    .core_drdy_o(core_drdy_o), .core_ciphertext(core_ciphertext), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [127:0] pt; logic [127:0] key; p_det_t pdet; int gcyc; } job_t;
  typedef struct { bit err; int idx; logic [127:0] ct; int due;
                   logic [127:0] pt; logic [127:0] key; p_det_t pdet; } exp_t;

  job_t job_q[$];
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Stimulus controls (written by the main sequence only)
  int core_mode = 0;   // 0 random latency, 1 never, 2 exactly TMO, 3 fixed 8, 4 random mix
  int pdet_mode = 0;   // 0 off, 1 random pulses, 2 A/B pulses during next WAIT
  bit fips_next = 1'b0;
  bit wd_fail   = 1'b0;
  int target[N];
  int issued[N];

  // Monitor-owned state
  logic [N-1:0] hs_vec = '0;
  int           due_cyc = -1;
  logic [127:0] due_ct = '0;
  bit           wd_reported = 1'b0;

  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int off = 1; off <= N; off++) begin
      if (v[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Requester drivers: keep a request up while the requester still has jobs queued.
  initial begin
    req_valid = '0; req_plaintext = '0; req_key = '0;
    for (int i = 0; i < N; i++) begin target[i] = 0; issued[i] = 0; end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (hs_vec[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && issued[i] < target[i]) begin
          issued[i]++;
          req_valid[i] = 1'b1;
          if (fips_next && i == 0) begin
            req_plaintext[i] = FIPS_PT;
            req_key[i]       = FIPS_KEY;
          end else begin
            req_plaintext[i] = {$urandom, $urandom, $urandom, $urandom};
            req_key[i]       = {$urandom, $urandom, $urandom, $urandom};
          end
        end
      end
    end
  end

  // Core model: completes on the cycle chosen by the monitor, plus a stray
  // completion pulse one cycle later that the scheduler must ignore.
  initial begin
    core_drdy_o = 1'b0; core_ciphertext = '0;
    forever begin
      @(posedge clk); #1;
      core_drdy_o     = (cyc == due_cyc) || (due_cyc >= 0 && cyc == due_cyc + 1);
      core_ciphertext = (cyc == due_cyc) ? due_ct : {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // TRNG model
  initial begin
    bit     done = 1'b0;
    p_det_t a = 32'h1234_5678;
    p_det_t b = 32'h9abc_def1;
    p_det_valid = 1'b0; p_det_in = '0;
    forever begin
      @(posedge clk); #1;
      p_det_valid = 1'b0;
      if (pdet_mode == 1) begin
        if ($urandom_range(0, 5) == 0) begin p_det_valid = 1'b1; p_det_in = $urandom; end
      end else if (pdet_mode == 2 && !done && core_drdy_i) begin
        @(posedge clk); #1; p_det_valid = 1'b1; p_det_in = a;
        @(posedge clk); #1; p_det_in = b;
        @(posedge clk); #1; p_det_valid = 1'b0; done = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    int           last_model = N - 1;
    p_det_t       shadow_model = '0;
    logic [127:0] last_ct = '0;
    logic         prev_drdy = 1'b0;
    forever begin
      @(negedge clk);
      if (wd_fail && !wd_reported) begin
        wd_reported = 1'b1;
        chk("watchdog", 128'(wd_fail), 128'(0));
      end
      if (!rst_n) begin
        chk("reset_ctrl", 128'({req_ready, resp_valid, resp_err, core_drdy_i, core_abort, busy}), 128'(0));
        chk("reset_ct", resp_ciphertext, 128'(0));
        chk("reset_pdet", 128'(core_p_det), 128'(0));
        chk("reset_core_data", core_plaintext | core_key, 128'(0));
        job_q.delete(); exp_q.delete();
        last_model = N - 1; shadow_model = '0; last_ct = '0;
        prev_drdy = 1'b0; due_cyc = -1; hs_vec = '0;
      end else begin
        hs_vec = req_ready & req_valid;
        if (req_ready != '0 || (!busy && req_valid != '0)) begin
          int           pick;
          logic [N-1:0] exp_rdy;
          pick    = busy ? -1 : rr_pick(req_valid, last_model);
          exp_rdy = '0;
          if (pick >= 0) exp_rdy[pick] = 1'b1;
          chk("grant", 128'(req_ready), 128'(exp_rdy));
          if (pick >= 0) begin
            job_q.push_back('{pick, req_plaintext[pick], req_key[pick], shadow_model, cyc});
            last_model = pick;
          end
        end
        if (p_det_valid) shadow_model = p_det_in;

        if (core_drdy_i) begin
          if (prev_drdy || job_q.size() == 0) begin
            chk("launch_expected", 128'(1), 128'(0));
          end else begin
            job_t         j;
            int           k;
            logic [127:0] ct;
            j = job_q.pop_front();
            chk("launch_latency", 128'(cyc - j.gcyc), 128'(1));
            chk("core_pt", core_plaintext, j.pt);
            chk("core_key", core_key, j.key);
            chk("core_pdet", 128'(core_p_det), 128'(j.pdet));
            chk("busy_launch", 128'(busy), 128'(1));
            case (core_mode)
              1: k = -1;
              2: k = TMO;
              3: k = 8;
              4: begin
                int r = $urandom_range(0, 9);
                k = (r == 0) ? -1 : (r == 1) ? TMO : (r == 2) ? 1 : $urandom_range(1, TMO);
              end
              default: k = $urandom_range(1, TMO);
            endcase
            ct = core_fn(j.pt, j.key);
            if (k < 0) begin
              due_cyc = -1;
              exp_q.push_back('{1'b1, j.idx, ct, cyc + TMO + 1, j.pt, j.key, j.pdet});
            end else begin
              due_cyc = cyc + k;
              due_ct  = ct;
              exp_q.push_back('{1'b0, j.idx, ct, cyc + k + 1, j.pt, j.key, j.pdet});
            end
          end
        end
        prev_drdy = core_drdy_i;

        if (resp_valid != '0 || resp_err != '0 || core_abort) begin
          if (exp_q.size() == 0) begin
            chk("response_expected", 128'({resp_valid, resp_err, core_abort}), 128'(0));
          end else begin
            exp_t         e;
            logic [N-1:0] oh;
            e  = exp_q.pop_front();
            oh = '0; oh[e.idx] = 1'b1;
            chk("resp_valid", 128'(resp_valid), e.err ? 128'(0) : 128'(oh));
            chk("resp_err", 128'(resp_err), e.err ? 128'(oh) : 128'(0));
            chk("core_abort", 128'(core_abort), 128'(e.err));
            chk("resp_time", 128'(cyc), 128'(e.due));
            chk("resp_ct", resp_ciphertext, e.err ? last_ct : e.ct);
            chk("hold_pt", core_plaintext, e.pt);
            chk("hold_key", core_key, e.key);
            chk("hold_pdet", 128'(core_p_det), 128'(e.pdet));
            $display("job req=%0d %s ct=%h cycle=%0d", e.idx, e.err ? "timeout" : "done", resp_ciphertext, cyc);
            if (!e.err) last_ct = e.ct;
          end
        end
      end
    end
  end

  task automatic drain();
    int  n = 0;
    bit  idle_now = 1'b0;
    while (!idle_now && n < 3000) begin
      @(negedge clk); #1;
      n++;
      idle_now = (req_valid == '0) && !busy && exp_q.size() == 0 && job_q.size() == 0;
      for (int i = 0; i < N; i++) if (issued[i] != target[i]) idle_now = 1'b0;
    end
    if (!idle_now) wd_fail = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Known-answer job on requester 0
    fips_next = 1'b1; target[0] += 1; drain(); fips_next = 1'b0;

    // Two requesters contending continuously
    target[0] += 4; target[1] += 4; drain();

    // Core never completes, then completes on the last allowed cycle
    core_mode = 1; target[2] += 1; drain();
    core_mode = 2; target[1] += 1; drain();

    // Randomized mix of requesters, latencies, timeouts and TRNG updates
    core_mode = 4; pdet_mode = 1;
    for (int i = 0; i < N; i++) target[i] += $urandom_range(3, 6);
    drain();

    // Polynomial updates during WAIT affect only the following job
    pdet_mode = 0; repeat (2) @(posedge clk);
    core_mode = 3; pdet_mode = 2; target[0] += 2; drain();
    pdet_mode = 0;

    // Reset in the middle of WAIT, then all requesters at once
    core_mode = 1; target[2] += 1;
    n = 0;
    while (!core_drdy_i && n < 200) begin @(negedge clk); n++; end
    if (!core_drdy_i) wd_fail = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    core_mode = 0;
    for (int i = 0; i < N; i++) target[i] += 1;
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
